// File: rtl/arith_engine.sv
// Handshaked WIDTH-bit arithmetic engine: single-cycle ALU ops plus a
// restoring divider, with the result held until the consumer takes it.
module arith_engine #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem,
  output logic             ovf,
  output logic             dz,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_HOLD
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;

  state_e state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic dz_q, dz_d;
  logic zero_q, zero_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod, shl;
  logic               big_sh;

  always_comb begin
    sum     = {1'b0, in1} + {1'b0, in2};
    diff    = {1'b0, in1} - {1'b0, in2};
    prod    = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
    shl     = {{WIDTH{1'b0}}, in1} << in2;
    big_sh  = {1'b0, in2} >= (WIDTH+1)'(WIDTH);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_ovf = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_ovf = diff[WIDTH];
      end
      OP_MUL: begin
        alu_res = prod[WIDTH-1:0];
        alu_ovf = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: alu_res = '1;
      OP_SHL: begin
        alu_res = big_sh ? '0 : shl[WIDTH-1:0];
        alu_ovf = big_sh ? |in1 : |shl[2*WIDTH-1:WIDTH];
      end
      OP_SHR: alu_res = big_sh ? '0 : in1 >> in2;
      OP_CMP: alu_res[2:0] = {in1 < in2, in1 > in2, in1 == in2};
      default: alu_res[2:0] = {^in1, |in1, &in1};
    endcase
  end

  // One restoring step: the dividend register doubles as the quotient.
  logic [WIDTH:0]   trial, trial_sub;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_n, prem_n;

  always_comb begin
    trial     = {prem_q, dvd_q[WIDTH-1]};
    trial_sub = trial - {1'b0, dvs_q};
    q_bit     = ~trial_sub[WIDTH];
    prem_n    = q_bit ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_n     = {dvd_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    zero_d   = zero_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    prem_d   = prem_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_DIV && in2 != '0) begin
            dvd_d   = in1;
            dvs_d   = in2;
            prem_d  = '0;
            cnt_d   = '0;
            state_d = S_DIV;
          end else begin
            result_d = alu_res;
            rem_d    = (op == OP_DIV) ? in1 : '0;
            ovf_d    = alu_ovf;
            dz_d     = (op == OP_DIV);
            zero_d   = (alu_res == '0);
            state_d  = S_HOLD;
          end
        end
      end
      S_DIV: begin
        dvd_d  = dvd_n;
        prem_d = prem_n;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          result_d = dvd_n;
          rem_d    = prem_n;
          ovf_d    = 1'b0;
          dz_d     = 1'b0;
          zero_d   = (dvd_n == '0);
          state_d  = S_HOLD;
        end
      end
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      zero_q   <= 1'b1;
      dvd_q    <= '0;
      dvs_q    <= '0;
      prem_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      zero_q   <= zero_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      prem_q   <= prem_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign result    = result_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_arith_engine.sv
// Bench for arith_engine at WIDTH 4, 8 and 16 against an arithmetic model.
// One instance is selected at a time; the others see idle handshakes.
module tb_arith_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  int          sel = 0;
  int          w = 4;
  int          n_err = 0;
  int          n_chk = 0;

  always #5 clk = ~clk;

  logic        ir4, ov4, of4, dz4, zr4;
  logic [3:0]  r4, m4;
  logic        ir8, ov8, of8, dz8, zr8;
  logic [7:0]  r8, m8;
  logic        ir16, ov16, of16, dz16, zr16;
  logic [15:0] r16, m16;

  arith_engine #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 0), .in_ready(ir4),
    .op(op), .in1(a[3:0]), .in2(b[3:0]), .out_valid(ov4),
    .out_ready(ordy && sel == 0), .result(r4), .rem(m4),
    .ovf(of4), .dz(dz4), .zero(zr4));

  arith_engine #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 1), .in_ready(ir8),
    .op(op), .in1(a[7:0]), .in2(b[7:0]), .out_valid(ov8),
    .out_ready(ordy && sel == 1), .result(r8), .rem(m8),
    .ovf(of8), .dz(dz8), .zero(zr8));

  arith_engine #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 2), .in_ready(ir16),
    .op(op), .in1(a[15:0]), .in2(b[15:0]), .out_valid(ov16),
    .out_ready(ordy && sel == 2), .result(r16), .rem(m16),
    .ovf(of16), .dz(dz16), .zero(zr16));

  logic        o_ir, o_ov, o_of, o_dz, o_zr;
  logic [31:0] o_res, o_rem;

  always_comb begin
    o_ir = ir4; o_ov = ov4; o_of = of4; o_dz = dz4; o_zr = zr4;
    o_res = 32'(r4); o_rem = 32'(m4);
    if (sel == 1) begin
      o_ir = ir8; o_ov = ov8; o_of = of8; o_dz = dz8; o_zr = zr8;
      o_res = 32'(r8); o_rem = 32'(m8);
    end else if (sel == 2) begin
      o_ir = ir16; o_ov = ov16; o_of = of16; o_dz = dz16; o_zr = zr16;
      o_res = 32'(r16); o_rem = 32'(m16);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int wd, input logic [2:0] o,
      input longint x, input longint y, output longint r,
      output longint rm, output logic ov, output logic d);
    longint m;
    m = longint'(1) << wd;
    r = 0; rm = 0; ov = 1'b0; d = 1'b0;
    case (o)
      3'd0: begin r = (x + y) % m; ov = (x + y) >= m; end
      3'd1: begin r = (x - y + m) % m; ov = x < y; end
      3'd2: begin r = (x * y) % m; ov = (x * y) >= m; end
      3'd3: begin
        if (y == 0) begin r = m - 1; rm = x; d = 1'b1; end
        else begin r = x / y; rm = x % y; end
      end
      3'd4: begin
        if (y >= wd) begin r = 0; ov = x != 0; end
        else begin r = (x << y) % m; ov = (x << y) >= m; end
      end
      3'd5: r = (y >= wd) ? 0 : x >> y;
      3'd6: r = (x < y ? 4 : 0) + (x > y ? 2 : 0) + (x == y ? 1 : 0);
      default: r = (x == m - 1 ? 1 : 0) + (x != 0 ? 2 : 0)
                 + ($countones(x) % 2 == 1 ? 4 : 0);
    endcase
  endfunction

  task automatic use_inst(input int s);
    sel = s;
    w = (s == 0) ? 4 : (s == 1) ? 8 : 16;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " in_ready"}, o_ir, 1);
    check({tag, " out_valid"}, o_ov, 0);
    check({tag, " result"}, o_res, 0);
    check({tag, " rem"}, o_rem, 0);
    check({tag, " ovf"}, o_of, 0);
    check({tag, " dz"}, o_dz, 0);
    check({tag, " zero"}, o_zr, 1);
  endtask

  logic [31:0] g_res, g_rem;
  logic        g_of, g_dz, g_zr;

  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    check("pre in_ready", o_ir, 1);
    iv = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 iv = 1'b0;
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y);
    longint er, erm;
    logic   eo, ed;
    int     lat, elat;
    model(w, o, longint'(x), longint'(y), er, erm, eo, ed);
    elat = (o == 3'd3 && y != 0) ? w + 1 : 1;
    issue(o, x, y);
    lat = 1;
    while (!o_ov && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    g_res = o_res; g_rem = o_rem; g_of = o_of; g_dz = o_dz; g_zr = o_zr;
    check($sformatf("w%0d op%0d latency", w, o), lat, elat);
    check($sformatf("w%0d op%0d %0d,%0d result", w, o, x, y), g_res, er);
    check($sformatf("w%0d op%0d rem", w, o), g_rem, erm);
    check($sformatf("w%0d op%0d ovf", w, o), g_of, eo);
    check($sformatf("w%0d op%0d dz", w, o), g_dz, ed);
    check($sformatf("w%0d op%0d zero", w, o), g_zr, er == 0);
    check($sformatf("w%0d op%0d in_ready held", w, o), o_ir, 0);
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    check($sformatf("w%0d op%0d release", w, o), {o_ir, o_ov}, 2'b10);
  endtask

  initial begin
    int seen;
    logic [31:0] mask, x, y;
    logic [2:0]  ro;

    use_inst(0);
    repeat (3) @(posedge clk);
    #1 chk_reset("por");
    @(negedge clk) rst = 1'b1;

    run(3'd0, 32'd1, 32'd2);
    issue(3'd0, 32'd9, 32'd9);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset("async rst");
    @(negedge clk) rst = 1'b1;
    #1 chk_reset("after rst");

    run(3'd0, 32'd9, 32'd8);
    check("add98 result", g_res, 1);
    check("add98 ovf", g_of, 1);
    check("add98 zero", g_zr, 0);

    run(3'd3, 32'd13, 32'd3);
    check("div13/3 q", g_res, 4);
    check("div13/3 r", g_rem, 1);
    run(3'd3, 32'd7, 32'd0);
    check("div7/0 q", g_res, 15);
    check("div7/0 r", g_rem, 7);
    check("div7/0 dz", g_dz, 1);

    run(3'd6, 32'd5, 32'd9);
    check("cmp5,9", g_res, 4);
    run(3'd7, 32'b1011, 32'd0);
    check("red1011", g_res, 6);
    run(3'd1, 32'd3, 32'd5);
    check("sub3-5 result", g_res, 14);
    check("sub3-5 ovf", g_of, 1);

    issue(3'd0, 32'd2, 32'd2);
    #1 check("bp valid", o_ov, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv = i[0]; op = 3'd2; a = 32'd3; b = 32'd3;
      @(posedge clk);
      #1 check($sformatf("bp hold %0d", i),
               {o_ov, o_ir, o_res}, {1'b1, 1'b0, 32'd4});
    end
    @(negedge clk);
    iv = 1'b0; ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    check("bp to idle", {o_ir, o_ov}, 2'b10);
    @(posedge clk);
    #1 check("bp nothing taken", {o_ir, o_ov}, 2'b10);

    use_inst(1);
    run(3'd2, 32'd20, 32'd13);
    check("mul20*13 result", g_res, 4);
    check("mul20*13 ovf", g_of, 1);
    run(3'd4, 32'h81, 32'd1);
    check("shl81by1 result", g_res, 2);
    check("shl81by1 ovf", g_of, 1);
    run(3'd4, 32'h81, 32'd9);
    check("shl by 9 result", g_res, 0);
    check("shl by 9 zero", g_zr, 1);

    use_inst(2);
    issue(3'd3, 32'd50000, 32'd7);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset("rst mid div");
    @(negedge clk) rst = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (o_ov) seen++;
    end
    check("no result after abort", seen, 0);
    run(3'd3, 32'd50000, 32'd7);
    check("div50000/7 q", g_res, 7142);
    check("div50000/7 r", g_rem, 6);

    for (int s = 0; s < 3; s++) begin
      use_inst(s);
      mask = (32'd1 << w) - 32'd1;
      for (int k = 0; k < 40; k++) begin
        ro = 3'($urandom_range(0, 7));
        x = $urandom & mask;
        y = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w + 1)
                                        : ($urandom & mask);
        run(ro, x, y);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
